// File: rtl/fabosc_reset_sequencer.sv
// Fabric reset sequencer and timebase on the fabric RC-oscillator clock.
// Fabric reset stays asserted until init, lock and user reset request are all
// qualified and lock has been stable; then 1 us / 1 ms strobes run freely.
// Optional build macro: FABOSC_LOCK_TIMEOUT_EN (sticky WAIT_LOCK timeout flag).
module fabosc_reset_sequencer #(
  parameter int unsigned CLK_FREQ_MHZ        = 50,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic CLK_BASE,
  input  logic POWER_ON_RESET_N,
  input  logic INIT_DONE,
  input  logic CCC_LOCK,
  input  logic FAB_RESET_N,
  input  logic CLR_LOST,
  output logic FAB_RESET_N_OUT,
  output logic READY,
  output logic TICK_1US,
  output logic TICK_1MS,
  output logic LOCK_LOST,
  output logic LOCK_TIMEOUT
);

  localparam int unsigned STAB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES) + 1;
  localparam int unsigned US_W   = $clog2(CLK_FREQ_MHZ) + 1;
  localparam int unsigned MS_W   = $clog2(1000) + 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [US_W-1:0]   US_LAST   = US_W'(CLK_FREQ_MHZ - 1);
  localparam logic [US_W-1:0]   US_PRE    = US_W'(CLK_FREQ_MHZ - 2);
  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(999);

  // Reject parameter values the counters cannot honour
  if (CLK_FREQ_MHZ < 2 || LOCK_STABLE_CYCLES < 2 || RESET_HOLD_CYCLES < 1 ||
      LOCK_TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fabosc_reset_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_STABLE,
    S_HOLD,
    S_RUN,
    S_LOST
  } state_t;

  state_t            state;
  logic [2:0]        sync1;
  logic [2:0]        sync2;
  logic              qual_init;
  logic              qual_lock;
  logic              qual_usr;
  logic              go_c;
  logic              lost_set_c;
  logic [STAB_W-1:0] stab_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              run_q;
  logic [US_W-1:0]   us_cnt;
  logic [MS_W-1:0]   ms_cnt;

  // Two-flop synchronisers for the asynchronous qualifiers {init, lock, usr}
  always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= {INIT_DONE, CCC_LOCK, FAB_RESET_N};
      sync2 <= sync1;
    end
  end

  assign qual_init = sync2[2];
  assign qual_lock = sync2[1];
  assign qual_usr  = sync2[0];

  // Release qualifier and lock-loss detect
  always_comb begin
    go_c       = qual_init & qual_lock & qual_usr;
    lost_set_c = (state == S_RUN) && !qual_lock;
  end

  // Sequencer: stabilise, hold, run; any dropped qualifier restarts the sequence
  always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N) begin
      state    <= S_WAIT_LOCK;
      stab_cnt <= '0;
      hold_cnt <= '0;
      run_q    <= 1'b0;
    end else begin
      run_q <= 1'b0;
      case (state)
        S_WAIT_LOCK: begin
          stab_cnt <= '0;
          if (go_c) state <= S_STABLE;
        end
        S_STABLE: begin
          if (!go_c) begin
            state    <= S_WAIT_LOCK;
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end
        S_HOLD: begin
          if (!go_c) begin
            state <= S_WAIT_LOCK;
          end else if (hold_cnt == HOLD_LAST) begin
            state <= S_RUN;
            run_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          if (!qual_lock)  state <= S_LOST;
          else if (!go_c)  state <= S_WAIT_LOCK;
          else             run_q <= 1'b1;
        end
        S_LOST:  state <= S_WAIT_LOCK;
        default: state <= S_WAIT_LOCK;
      endcase
    end
  end

  assign FAB_RESET_N_OUT = run_q;
  assign READY           = run_q;

  // Sticky lock-lost flag; a new loss beats a simultaneous clear
  always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N)  LOCK_LOST <= 1'b0;
    else if (lost_set_c)    LOCK_LOST <= 1'b1;
    else if (CLR_LOST)      LOCK_LOST <= 1'b0;
  end

  // Free-running 1 us / 1 ms strobes, registered so they align with the counts
  always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N) begin
      us_cnt   <= '0;
      ms_cnt   <= '0;
      TICK_1US <= 1'b0;
      TICK_1MS <= 1'b0;
    end else begin
      if (us_cnt == US_LAST) begin
        us_cnt <= '0;
        ms_cnt <= (ms_cnt == MS_LAST) ? '0 : ms_cnt + MS_W'(1);
      end else begin
        us_cnt <= us_cnt + US_W'(1);
      end
      TICK_1US <= (us_cnt == US_PRE);
      TICK_1MS <= (us_cnt == US_PRE) && (ms_cnt == MS_LAST);
    end
  end

`ifdef FABOSC_LOCK_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;
  logic              enter_hold_c;

  assign enter_hold_c = (state == S_STABLE) && go_c && (stab_cnt == STAB_LAST);

  // Time spent waiting for lock; saturates and raises a sticky timeout
  always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
    if (!POWER_ON_RESET_N) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (enter_hold_c)
        wait_cnt <= '0;
      else if ((state == S_WAIT_LOCK || state == S_STABLE) && wait_cnt != WAIT_LAST)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_cnt == WAIT_LAST) timeout_q <= 1'b1;
      else if (CLR_LOST)         timeout_q <= 1'b0;
    end
  end

  assign LOCK_TIMEOUT = timeout_q;
`else
  assign LOCK_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_fabosc_reset_sequencer.sv
// Bench for fabosc_reset_sequencer: directed scenarios plus a random phase,
// all outputs compared every cycle with a behavioural model.
module tb_fabosc_reset_sequencer;

  localparam int unsigned F   = 5;
  localparam int unsigned LSC = 8;
  localparam int unsigned RHC = 4;
  localparam int unsigned LTC = 32;
  // consecutive qualified cycles needed before the release shows up
  localparam int          NREL = LSC + RHC + 1;

  logic clk = 1'b0;
  logic rst_n, init_done, ccc_lock, fab_rst_n, clr_lost;
  logic fab_reset_n_out, ready, tick_1us, tick_1ms, lock_lost, lock_timeout;

  fabosc_reset_sequencer #(
    .CLK_FREQ_MHZ(F), .LOCK_STABLE_CYCLES(LSC),
    .RESET_HOLD_CYCLES(RHC), .LOCK_TIMEOUT_CYCLES(LTC)
  ) dut (
    .CLK_BASE(clk), .POWER_ON_RESET_N(rst_n), .INIT_DONE(init_done),
    .CCC_LOCK(ccc_lock), .FAB_RESET_N(fab_rst_n), .CLR_LOST(clr_lost),
    .FAB_RESET_N_OUT(fab_reset_n_out), .READY(ready), .TICK_1US(tick_1us),
    .TICK_1MS(tick_1ms), .LOCK_LOST(lock_lost), .LOCK_TIMEOUT(lock_timeout)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: input history, run of qualified cycles, sticky flag, edge count
  logic [2:0] hist1, hist2;
  int         run_len;
  bit         lost_pend;
  bit         m_lost;
  int         n_edge;
  bit         chk_to;
  int         first_ms = -1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, n_edge);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist1 = 3'b000; hist2 = 3'b000;
    run_len = 0; lost_pend = 1'b0; m_lost = 1'b0; n_edge = 0;
  endtask

  function automatic logic m_ready();
    return (run_len >= NREL) && !lost_pend;
  endfunction

  // One clock edge: inputs reach the sequencer two edges after being sampled
  task automatic model_edge();
    logic [2:0] q;
    bit set;
    q = hist2; hist2 = hist1; hist1 = {init_done, ccc_lock, fab_rst_n};
    set = 1'b0;
    if (lost_pend) begin
      lost_pend = 1'b0;
      run_len   = 0;
    end else if (&q) begin
      if (run_len < NREL) run_len++;
    end else begin
      if (run_len >= NREL && !q[1]) begin
        lost_pend = 1'b1;
        set       = 1'b1;
      end
      run_len = 0;
    end
    if (set)           m_lost = 1'b1;
    else if (clr_lost) m_lost = 1'b0;
    n_edge++;
  endtask

  task automatic check_all();
    chk("fab_reset_n_out", fab_reset_n_out, m_ready());
    chk("ready", ready, m_ready());
    chk("tick_1us", tick_1us, n_edge > 0 && (n_edge % F) == F - 1);
    chk("tick_1ms", tick_1ms, n_edge > 0 && (n_edge % (F * 1000)) == F * 1000 - 1);
    chk("lock_lost", lock_lost, m_lost);
`ifdef FABOSC_LOCK_TIMEOUT_EN
    if (chk_to) chk("lock_timeout", lock_timeout, n_edge >= LTC);
`else
    chk("lock_timeout", lock_timeout, 1'b0);
`endif
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      if (rst_n) model_edge();
      else       model_reset();
      #1;
      check_all();
      if (rst_n && tick_1ms === 1'b1 && first_ms < 0) first_ms = n_edge;
    end
  endtask

  initial begin
    int rel_edge, d, lat;

    // Reset: outputs low while POR is held
    rst_n = 1'b0; init_done = 1'b1; fab_rst_n = 1'b1; ccc_lock = 1'b0;
    clr_lost = 1'b0; chk_to = 1'b0;
    model_reset();
    #12 check_all();
    step(2);
    rst_n = 1'b1;

    // Lock rises at cycle 10, release expected at cycle 25
    step(10);
    ccc_lock = 1'b1;
    rel_edge = -1;
    for (int i = 0; i < 30 && rel_edge < 0; i++) begin
      step(1);
      if (fab_reset_n_out === 1'b1) rel_edge = n_edge;
    end
    chk_int("release_edge", rel_edge, 25);

    // Lock drop in RUN: reset within 3 cycles, sticky LOCK_LOST, full re-release
    step(5);
    ccc_lock = 1'b0;
    d = -1;
    for (int i = 1; i <= 6 && d < 0; i++) begin
      step(1);
      if (fab_reset_n_out === 1'b0) d = i;
    end
    chk("lock_drop_within_3", d >= 1 && d <= 3, 1'b1);
    ccc_lock = 1'b1;
    step(25);
    chk("re_release_ready", ready, 1'b1);
    chk("lock_lost_sticky", lock_lost, 1'b1);
    clr_lost = 1'b1; step(1); clr_lost = 1'b0;
    step(2);

    // Lock glitch during STABLE: sequence restarts from scratch
    ccc_lock = 1'b0; step(6);
    clr_lost = 1'b1; step(1); clr_lost = 1'b0;
    ccc_lock = 1'b1; step(6);
    ccc_lock = 1'b0; step(3);
    ccc_lock = 1'b1;
    lat = -1;
    for (int i = 1; i <= 30 && lat < 0; i++) begin
      step(1);
      if (fab_reset_n_out === 1'b1) lat = i;
    end
    chk_int("stable_glitch_release_latency", lat, 15);

    // User reset pulse in RUN: reset within 3 cycles, LOCK_LOST untouched
    step(3);
    fab_rst_n = 1'b0; step(1); fab_rst_n = 1'b1;
    d = -1;
    for (int i = 2; i <= 6 && d < 0; i++) begin
      step(1);
      if (fab_reset_n_out === 1'b0) d = i;
    end
    chk("usr_reset_within_3", d >= 1 && d <= 3, 1'b1);
    step(20);

    // Random qualifier activity and clear pulses
    for (int i = 0; i < 400; i++) begin
      if (ccc_lock ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 3) == 0))
        ccc_lock = ~ccc_lock;
      if (init_done ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0))
        init_done = ~init_done;
      if (fab_rst_n ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0))
        fab_rst_n = ~fab_rst_n;
      clr_lost = ($urandom_range(0, 30) == 0);
      step(1);
    end
    init_done = 1'b1; fab_rst_n = 1'b1; ccc_lock = 1'b1; clr_lost = 1'b0;

    // Run through the first millisecond strobe
    for (int i = 0; i < 6000 && n_edge < 5010; i++) step(1);
    chk_int("first_tick_1ms_edge", first_ms, 4999);

    // POR asserted mid-HOLD clears every output without waiting for a clock
    ccc_lock = 1'b0; step(6);
    clr_lost = 1'b1; step(1); clr_lost = 1'b0;
    ccc_lock = 1'b1; step(12);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    step(3);

    // Lock never arrives: timeout flag after LTC cycles when the feature is built
    ccc_lock = 1'b0;
    rst_n = 1'b1;
    chk_to = 1'b1;
    step(40);
    chk_to = 1'b0;
    ccc_lock = 1'b1;
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
